// File: rtl/chacha_block_core_pkg.sv
// chacha_block_core_pkg: shared ChaCha20 types, constants and quarter-round index table.
package chacha_pkg;
  typedef logic [31:0] word_t;
  typedef word_t [15:0] state_t;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;
  localparam word_t SIGMA [4] = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574};
  // Rows 0-3 are column rounds, rows 4-7 diagonal rounds; consumed cyclically.
  localparam logic [3:0] QR_IDX [8][4] = '{
    '{4'd0, 4'd4, 4'd8,  4'd12},
    '{4'd1, 4'd5, 4'd9,  4'd13},
    '{4'd2, 4'd6, 4'd10, 4'd14},
    '{4'd3, 4'd7, 4'd11, 4'd15},
    '{4'd0, 4'd5, 4'd10, 4'd15},
    '{4'd1, 4'd6, 4'd11, 4'd12},
    '{4'd2, 4'd7, 4'd8,  4'd13},
    '{4'd3, 4'd4, 4'd9,  4'd14}
  };
  function automatic state_t init_state(input logic [255:0] key, input word_t counter,
                                        input logic [95:0] nonce);
    state_t s;
    for (int i = 0; i < 4; i++) s[i] = SIGMA[i];
    s[11:4] = key;
    s[12] = counter;
    s[15:13] = nonce;
    return s;
  endfunction
endpackage

// File: rtl/chacha_block_core_if.sv
// chacha_block_core_if: request/response bus of the ChaCha block core.
// CHACHA_XOR_EN adds the data_i word block that is XORed into the output.
interface chacha_block_core_if;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] key_i;
  logic [31:0]  counter_i;
  logic [95:0]  nonce_i;
`ifdef CHACHA_XOR_EN
  logic [511:0] data_i;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [511:0] block_o;
  modport master (
`ifdef CHACHA_XOR_EN
    output data_i,
`endif
    output in_valid, key_i, counter_i, nonce_i, out_ready,
    input  in_ready, out_valid, block_o
  );
  modport slave (
`ifdef CHACHA_XOR_EN
    input  data_i,
`endif
    input  in_valid, key_i, counter_i, nonce_i, out_ready,
    output in_ready, out_valid, block_o
  );
endinterface

// File: rtl/chacha_quarter_round.sv
// chacha_quarter_round: combinational ChaCha quarter-round (add/xor/rotate 16,12,8,7).
module chacha_quarter_round #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] na,
  output logic [WIDTH-1:0] nb,
  output logic [WIDTH-1:0] nc,
  output logic [WIDTH-1:0] nd
);
  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x, input int n);
    return (x << n) | (x >> (WIDTH - n));
  endfunction
  logic [WIDTH-1:0] a1, b1, c1, d1;
  always_comb begin
    a1 = a + b;
    d1 = rotl(d ^ a1, 16);
    c1 = c + d1;
    b1 = rotl(b ^ c1, 12);
    na = a1 + b1;
    nd = rotl(d1 ^ na, 8);
    nc = c1 + nd;
    nb = rotl(b1 ^ nc, 7);
  end
endmodule

// File: rtl/chacha_block_core.sv
// chacha_block_core: iterative ChaCha20 block function, QR_PER_CYCLE quarter-rounds per clock.
// Define CHACHA_XOR_EN to XOR a captured data_i block into the output.
module chacha_block_core
  import chacha_pkg::*;
#(
  parameter int ROUNDS       = 20,
  parameter int QR_PER_CYCLE = 4
) (
  input logic clk,
  input logic rst,
  chacha_block_core_if.slave bus
);
  localparam int N  = ROUNDS * 4 / QR_PER_CYCLE;
  localparam int SW = $clog2(N);
  if (ROUNDS != 8 && ROUNDS != 12 && ROUNDS != 20) begin : g_bad_rounds
    $error("chacha_block_core: ROUNDS must be 8, 12 or 20");
  end
  if (QR_PER_CYCLE != 1 && QR_PER_CYCLE != 2 && QR_PER_CYCLE != 4) begin : g_bad_qpc
    $error("chacha_block_core: QR_PER_CYCLE must be 1, 2 or 4");
  end
  fsm_t state, state_n;
  state_t work, saved, work_n, sum, blk;
  logic [SW-1:0] step;
  logic last;
  logic [2:0] idx [QR_PER_CYCLE];
  word_t qa [QR_PER_CYCLE];
  word_t qb [QR_PER_CYCLE];
  word_t qc [QR_PER_CYCLE];
  word_t qd [QR_PER_CYCLE];
`ifdef CHACHA_XOR_EN
  state_t data;
`endif
  assign last = step == SW'(N - 1);
  // QR_PER_CYCLE divides 4, so one cycle never mixes column and diagonal groups.
  for (genvar k = 0; k < QR_PER_CYCLE; k++) begin : g_qr
    assign idx[k] = 3'(int'(step) * QR_PER_CYCLE + k);
    chacha_quarter_round #(.WIDTH(32)) u_qr (
      .a(work[QR_IDX[idx[k]][0]]),
      .b(work[QR_IDX[idx[k]][1]]),
      .c(work[QR_IDX[idx[k]][2]]),
      .d(work[QR_IDX[idx[k]][3]]),
      .na(qa[k]),
      .nb(qb[k]),
      .nc(qc[k]),
      .nd(qd[k])
    );
  end
  always_comb begin
    work_n = work;
    for (int k = 0; k < QR_PER_CYCLE; k++) begin
      work_n[QR_IDX[idx[k]][0]] = qa[k];
      work_n[QR_IDX[idx[k]][1]] = qb[k];
      work_n[QR_IDX[idx[k]][2]] = qc[k];
      work_n[QR_IDX[idx[k]][3]] = qd[k];
    end
  end
  always_comb begin
    sum = '0;
    for (int i = 0; i < 16; i++) sum[i] = work[i] + saved[i];
  end
  always_comb begin
    state_n = state == IDLE  ? (bus.in_valid ? ROUND : IDLE) :
              state == ROUND ? (last ? FINAL : ROUND) :
              state == FINAL ? DONE :
              (bus.out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      work  <= '0;
      saved <= '0;
      step  <= '0;
      blk   <= '0;
`ifdef CHACHA_XOR_EN
      data  <= '0;
`endif
    end else begin
      if (state == IDLE && bus.in_valid) begin
        work  <= init_state(bus.key_i, bus.counter_i, bus.nonce_i);
        saved <= init_state(bus.key_i, bus.counter_i, bus.nonce_i);
        step  <= '0;
`ifdef CHACHA_XOR_EN
        data  <= bus.data_i;
`endif
      end
      if (state == ROUND) begin
        work <= work_n;
        step <= step + 1'b1;
      end
`ifdef CHACHA_XOR_EN
      if (state == FINAL) blk <= sum ^ data;
`else
      if (state == FINAL) blk <= sum;
`endif
    end
  end
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.block_o   = blk;
endmodule

// File: tb/tb_chacha_block_core.sv
// tb_chacha_block_core: directed scoreboard bench over QR_PER_CYCLE = 4, 1 and 2 instances.
module tb_chacha_block_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [2:0]   req = '0;
  logic [255:0] key;
  logic [31:0]  ctr;
  logic [95:0]  nonce;
  logic         out_ready;
`ifdef CHACHA_XOR_EN
  logic [511:0] data;
`endif
  logic [2:0]   rdy, ov;
  logic [511:0] blk [3];
  int errors = 0;
  int checks = 0;
  logic [511:0] sb [$];

  localparam logic [255:0] RFC_KEY = {32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
                                      32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100};
  localparam logic [95:0]  RFC_NONCE = {32'h00000000, 32'h4a000000, 32'h09000000};
  localparam logic [511:0] RFC_BLOCK = {
    32'h4e3c50a2, 32'he883d0cb, 32'hb94e16de, 32'hd19c12b5,
    32'ha2028bd9, 32'h05d7c214, 32'h09aa9f07, 32'h466482d2,
    32'h4e6cd4c3, 32'h9aaa2204, 32'h0368c033, 32'hc7f4d1c7,
    32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    chacha_block_core_if ifc ();
    chacha_block_core #(.ROUNDS(20), .QR_PER_CYCLE(g == 0 ? 4 : g == 1 ? 1 : 2)) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc.slave)
    );
    assign ifc.in_valid  = req[g];
    assign ifc.key_i     = key;
    assign ifc.counter_i = ctr;
    assign ifc.nonce_i   = nonce;
    assign ifc.out_ready = out_ready;
`ifdef CHACHA_XOR_EN
    assign ifc.data_i    = data;
`endif
    assign rdy[g] = ifc.in_ready;
    assign ov[g]  = ifc.out_valid;
    assign blk[g] = ifc.block_o;
  end

  function automatic int lat_exp(input int d);
    return (d == 0 ? 20 : d == 1 ? 80 : 40) + 2;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a, b, c, d);
    a += b; d ^= a; d = rotl(d, 16);
    c += d; b ^= c; b = rotl(b, 12);
    a += b; d ^= a; d = rotl(d, 8);
    c += d; b ^= c; b = rotl(b, 7);
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [31:0] c,
                                             input logic [95:0] n);
    logic [31:0] s [16];
    logic [31:0] w [16];
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int j = 0; j < 8; j++) s[4+j] = k[32*j +: 32];
    s[12] = c;
    for (int j = 0; j < 3; j++) s[13+j] = n[32*j +: 32];
    w = s;
    for (int i = 0; i < 10; i++) begin
      {w[0], w[4], w[8],  w[12]} = qr(w[0], w[4], w[8],  w[12]);
      {w[1], w[5], w[9],  w[13]} = qr(w[1], w[5], w[9],  w[13]);
      {w[2], w[6], w[10], w[14]} = qr(w[2], w[6], w[10], w[14]);
      {w[3], w[7], w[11], w[15]} = qr(w[3], w[7], w[11], w[15]);
      {w[0], w[5], w[10], w[15]} = qr(w[0], w[5], w[10], w[15]);
      {w[1], w[6], w[11], w[12]} = qr(w[1], w[6], w[11], w[12]);
      {w[2], w[7], w[8],  w[13]} = qr(w[2], w[7], w[8],  w[13]);
      {w[3], w[4], w[9],  w[14]} = qr(w[3], w[4], w[9],  w[14]);
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i] + s[i];
    return r;
  endfunction

  function automatic logic [511:0] expected(input logic [31:0] c);
`ifdef CHACHA_XOR_EN
    return ref_block(key, c, nonce) ^ data;
`else
    return ref_block(key, c, nonce);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_out(input int d, input int n0);
    int n = n0;
    while (!ov[d] && n < 300) begin
      tick();
      n++;
    end
    check("latency", 512'(n), 512'(lat_exp(d)));
  endtask

  task automatic run(input int d, input logic [31:0] c);
    int n = 0;
    ctr = c;
    req[d] = 1'b1;
    while (!rdy[d] && n < 200) begin
      tick();
      n++;
    end
    check("ready_timeout", 512'(n < 200), 512'(1));
    sb.push_back(expected(c));
    tick();
    req[d] = 1'b0;
    wait_out(d, 1);
  endtask

  task automatic finish_out(input int d);
    logic [511:0] e;
    e = sb.size() > 0 ? sb.pop_front() : 'x;
    check("block", blk[d], e);
    check("busy_in_done", 512'(rdy[d]), 512'(0));
    tick();
    check("handshake_done", 512'({ov[d], rdy[d]}), 512'(2'b01));
  endtask

  initial begin
    logic [511:0] held;
    logic ok;
    int n;
    key = RFC_KEY;
    nonce = RFC_NONCE;
    ctr = 32'd1;
    out_ready = 1'b0;
`ifdef CHACHA_XOR_EN
    data = '0;
`endif
    tick();
    tick();
    rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check("reset_in_ready", 512'(rdy[d]), 512'(1));
      check("reset_out_valid", 512'(ov[d]), 512'(0));
      check("reset_block", blk[d], '0);
    end
    ok = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      ok &= rdy == 3'b111 && ov == 3'b000 && blk[0] == '0;
    end
    check("idle_stable", 512'(ok), 512'(1));

    for (int d = 0; d < 3; d++) begin
      run(d, 32'd1);
      check("rfc_vector", blk[d], RFC_BLOCK);
      finish_out(d);
    end

    out_ready = 1'b0;
    run(0, 32'd1);
    held = blk[0];
    ctr = 32'd2;
    req[0] = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      ok &= blk[0] == held && !rdy[0] && ov[0];
    end
    check("stall_stable", 512'(ok), 512'(1));
    out_ready = 1'b1;
    check("stall_block", blk[0], sb.pop_front());
    tick();
    check("reaccept_gap", 512'({ov[0], rdy[0]}), 512'(2'b01));
    sb.push_back(expected(32'd2));
    tick();
    check("reaccepted", 512'(rdy[0]), 512'(0));
    req[0] = 1'b0;
    wait_out(0, 1);
    finish_out(0);

    ctr = 32'd1;
    req[0] = 1'b1;
    tick();
    req[0] = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_state", 512'({ov[0], rdy[0]}), 512'(2'b01));
    check("abort_block", blk[0], '0);
    n = 0;
    while (n < 3 && !ov[0]) begin
      tick();
      n++;
    end
    check("abort_no_output", 512'(ov[0]), 512'(0));
    run(0, 32'd1);
    check("rfc_after_abort", blk[0], RFC_BLOCK);
    finish_out(0);

    run(0, 32'hffffffff);
    finish_out(0);
    key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    nonce = {$urandom, $urandom, $urandom};
    run(2, $urandom);
    finish_out(2);
    run(1, 32'hffffffff);
    finish_out(1);

`ifdef CHACHA_XOR_EN
    key = RFC_KEY;
    nonce = RFC_NONCE;
    data = '1;
    run(0, 32'd1);
    check("xor_rfc", blk[0], ~RFC_BLOCK);
    finish_out(0);
    data = '0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
